// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: bytes stored to TXDATA queue in a FIFO and go out 8N1 on uart_tx.
// Define UART_TX_PARITY_EN to add an even parity bit (8E1) and report it in STATUS bit4.
module uart_tx_mmio #(
    parameter int unsigned CLK_FREQ   = 25000000,
    parameter int unsigned BIT_RATE   = 115200,
    parameter logic [31:0] BASE_ADDR  = 32'h80000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        uart_tx
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BIT_RATE;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic PARITY_FLAG = 1'b1;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
    localparam logic PARITY_FLAG = 1'b0;
`endif

    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              sel, push_req, push, pop, full, empty, ovf_clear, busy;
    logic [31:0]       status;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              bit_done;
    logic              tx;
`ifdef UART_TX_PARITY_EN
    logic              parity_q;
`endif
    logic              unused_bits;

    assign sel       = (address[31:3] == BASE_ADDR[31:3]);
    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign push_req  = sel && memory_write && !address[2];
    assign push      = push_req && !full;
    assign ovf_clear = sel && memory_write && address[2] && write_data[3];
    assign busy      = (state_q != IDLE);
    assign bit_done  = (baud_q == BAUD_LAST);
    assign status    = {17'b0, 7'(count), 3'b0, PARITY_FLAG, overflow, busy, empty, full};
    assign read_data = (sel && memory_read && address[2]) ? status : 32'h0;
    assign uart_tx   = tx;
    assign unused_bits = &{1'b0, address[1:0], write_data[31:8]};

    // A push against a full FIFO is dropped even if the transmitter pops on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= write_data[7:0];
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^fifo_mem[rd_ptr];
        end
    end
`endif

    // Baud counter restarts at every bit boundary; IDLE pops on the same edge it leaves.
    always_comb begin
        state_d   = state_q;
        baud_d    = bit_done ? '0 : baud_q + BAUD_W'(1);
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
        tx        = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr];
                    state_d = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_done) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx = parity_q;
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                tx = 1'b1;
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed and random bus traffic checked cycle by cycle against a line/FIFO model.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx_mmio;
    localparam int          CPB   = 8;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h80000000;
    localparam logic [31:0] STAT  = 32'h80000004;
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN     = 1'b1;
    localparam int   FRAME_BITS = 11;
`else
    localparam logic PAR_EN     = 1'b0;
    localparam int   FRAME_BITS = 10;
`endif

    typedef struct packed {
        logic val;
        logic busy;
        logic pop;
    } elem_t;

    logic        clk;
    logic        reset;
    logic        memory_read;
    logic        memory_write;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        uart_tx;

    int    errors = 0;
    int    checks = 0;
    elem_t line_q[$];
    int    m_count = 0;
    logic  m_ovf = 1'b0;

    uart_tx_mmio #(
        .CLK_FREQ  (8),
        .BIT_RATE  (1),
        .BASE_ADDR (BASE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memory_read (memory_read),
        .memory_write(memory_write),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .uart_tx     (uart_tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelStatus(input logic busy);
        return {17'b0, 7'(m_count), 3'b0, PAR_EN, m_ovf, busy, (m_count == 0), (m_count == DEPTH)};
    endfunction

    // One idle cycle (where the byte is popped) followed by the frame, one entry per clock.
    task automatic appendFrame(input logic [7:0] b);
        elem_t e;
        logic  v;
        e.val = 1'b1; e.busy = 1'b0; e.pop = 1'b1;
        line_q.push_back(e);
        for (int n = 0; n < FRAME_BITS; n++) begin
            if (n == 0)                   v = 1'b0;
            else if (n <= 8)              v = b[n-1];
            else if (n == FRAME_BITS - 1) v = 1'b1;
            else                          v = ^b;
            e.val = v; e.busy = 1'b1; e.pop = 1'b0;
            repeat (CPB) line_q.push_back(e);
        end
    endtask

    // Called just after a falling edge: drive, check this cycle, then follow the rising edge in the model.
    task automatic applyStimulus(input logic rst_n, input logic rd, input logic wr,
                                 input logic [31:0] a, input logic [31:0] d);
        elem_t cur;
        logic  sel;
        reset = rst_n; memory_read = rd; memory_write = wr; address = a; write_data = d;
        #1;
        cur.val = 1'b1; cur.busy = 1'b0; cur.pop = 1'b0;
        if (line_q.size() > 0) cur = line_q[0];
        sel = (a[31:3] == BASE[31:3]);
        checkOutput("uart_tx", {31'b0, uart_tx}, {31'b0, cur.val});
        checkOutput("read_data", read_data, (rd && sel && a[2]) ? modelStatus(cur.busy) : 32'h0);
        @(posedge clk);
        if (!rst_n) begin
            line_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
        end else begin
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (sel && wr && a[2] && d[3]) m_ovf = 1'b0;
            if (sel && wr && !a[2]) begin
                if (m_count == DEPTH) m_ovf = 1'b1;
                else begin
                    appendFrame(d[7:0]);
                    m_count++;
                end
            end
            if (cur.pop) m_count--;
        end
        @(negedge clk);
    endtask

    task automatic pollCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, 1'b0, STAT, 32'h0);
    endtask

    task automatic drain();
        for (int g = 0; g < 3000 && line_q.size() > 0; g++) applyStimulus(1'b1, 1'b1, 1'b0, STAT, 32'h0);
        pollCycles(3);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned kind;
        reset = 1'b0; memory_read = 1'b0; memory_write = 1'b0; address = 32'h0; write_data = 32'h0;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, STAT, 32'h0);
        pollCycles(4);

        $display("[TB] single byte 0xA5");
        applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'h000000A5);
        drain();

        $display("[TB] FIFO fill and overflow");
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'h11 + 32'(i));
        pollCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b1, STAT, 32'hFFFFFFF7);
        pollCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b1, STAT, 32'h00000008);
        pollCycles(2);
        drain();

        $display("[TB] back-to-back 0x00 0xFF");
        applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b1, BASE + 32'd2, 32'hFF);
        drain();

        $display("[TB] decode and parity byte 0x07");
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h80000008, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, BASE, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, STAT, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h00000000, 32'h55);
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h80000008, 32'h66);
        applyStimulus(1'b1, 1'b1, 1'b0, STAT + 32'd3, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'h07);
        drain();

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'h3C);
        applyStimulus(1'b1, 1'b0, 1'b1, BASE, 32'hC3);
        pollCycles(20);
        applyStimulus(1'b0, 1'b1, 1'b0, STAT, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, STAT, 32'h0);
        pollCycles(100);

        $display("[TB] random traffic");
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            d    = $urandom;
            if (kind <= 5) begin
                a = BASE + 32'($urandom_range(0, 3));
                applyStimulus(1'b1, $urandom_range(0, 1) == 1, 1'b1, a, d);
            end else if (kind == 6) begin
                applyStimulus(1'b1, 1'b1, 1'b1, STAT + 32'($urandom_range(0, 3)), d);
            end else if (kind == 7) begin
                a = $urandom & 32'h7FFFFFFF;
                applyStimulus(1'b1, 1'b1, 1'b1, a, d);
            end else begin
                a = BASE + 32'($urandom_range(0, 15));
                applyStimulus(1'b1, 1'b1, 1'b0, a, 32'h0);
            end
            pollCycles($urandom_range(0, 40));
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the Core data bus, alongside Memory; same bus signals as Memory.
- Core stores bytes to a TX FIFO at BASE_ADDR, and the block serialises them 8N1 (optionally 8E1) on uart_tx.
- Status is readable so firmware can poll before writing.
- read_data is zero when not selected, so the top level may OR it with Memory's read_data.

Parameters:
- CLK_FREQ, 25000000, system clock in Hz.
- BIT_RATE, 115200, baud; CLKS_PER_BIT = CLK_FREQ/BIT_RATE (integer division, must be >= 2).
- BASE_ADDR, 32'h80000000, word-aligned base of the 8-byte register window.
- FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset: sampled on rising clk, clears all state while 0.
- memory_read  input  1  bus read strobe.
- memory_write  input  1  bus write strobe.
- address  input  32  byte address.
- write_data  input  32  store data.
- read_data  output  32  load data, combinational.
- uart_tx  output  1  serial line, idle high.

Behaviour:
- Select: sel = (address[31:3] == BASE_ADDR[31:3]). address[2] picks the register; address[1:0] are ignored.
- Reg 0x0 TXDATA:
  - Write pushes write_data[7:0] into the FIFO.
  - Read returns 0.
- Reg 0x4 STATUS (read):
  - bit0 full.
  - bit1 empty.
  - bit2 busy (FSM not IDLE).
  - bit3 overflow (sticky).
  - bits[14:8] FIFO count.
  - Other bits 0.
- Reg 0x4 STATUS (write): write_data[3]=1 clears overflow; other bits ignored.
- read_data = STATUS/0 when sel && memory_read, else 32'h0. No latency.
- Push occurs on the rising edge where sel && memory_write && address[2]==0.
  - If full at the start of that cycle, the byte is dropped and overflow is set.
  - Full + same-cycle pop still drops.
- memory_read and memory_write both high: the write takes effect; read_data is still driven.
- FIFO: circular buffer, wr/rd pointers wrap modulo FIFO_DEPTH. count is 0..FIFO_DEPTH; full when count==FIFO_DEPTH.
  - Simultaneous push and pop when not full and not empty: count unchanged.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE:
    - uart_tx=1.
    - If FIFO not empty: pop into shift reg, clear baud counter, go to START next cycle.
    - Pop happens on the same edge as the transition.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA:
    - uart_tx=shift[0], held CLKS_PER_BIT cycles.
    - Then shift right and bit_idx++.
    - After bit 7, go to STOP (or PARITY).
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back: a byte waiting in the FIFO starts 1 cycle after STOP ends (one IDLE cycle).
- Baud counter counts 0..CLKS_PER_BIT-1 and resets on every bit boundary.
- Reset values:
  - uart_tx=1.
  - FSM=IDLE.
  - FIFO pointers/count=0 (empty=1).
  - overflow=0.
  - Counters=0.
  - read_data follows its combinational rule.
- Reset mid-frame: line returns high on the next edge and the in-flight byte and FIFO contents are discarded.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - Drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame = 11 bit-times.
  - STATUS bit4 reads 1.
- Undefined:
  - No PARITY state; 10 bit-times per frame.
  - STATUS bit4 reads 0.

Test Plan:
- Reset (reset=0 four cycles) → uart_tx=1; STATUS read at 0x80000004 = 32'h00000002.
- CLK_FREQ=8, BIT_RATE=1, write 0xA5 to 0x80000000:
  - start bit low 8 cycles.
  - then bits 1,0,1,0,0,1,0,1, each 8 cycles.
  - stop high 8 cycles.
  - busy=1 throughout, then STATUS=0x2.
- FIFO_DEPTH=4, five writes 0x11..0x15 while the first is transmitting:
  - first pops immediately; writes 2–5 fill the FIFO.
  - STATUS shows full=1, count=4, overflow=0.
  - Sixth write 0x16 → overflow=1, byte never transmitted.
  - Write 0x8 to STATUS → overflow=0.
- Back-to-back 0x00 then 0xFF → exactly one idle-high cycle between the first stop bit and the second start bit.
- Read 0x80000008 (not selected) → read_data=0. Store to 0x00000000 → no push, count unchanged.
- Reset asserted mid-DATA → next edge uart_tx=1, STATUS=0x2, no residual bits after release.
- With UART_TX_PARITY_EN, send 0x07 → parity bit 1 after the data bits; frame lasts 88 cycles at the params above.
